// File: rtl/source_rr_arbiter.sv
// source_rr_arbiter: merges p_nreqs val/rdy source streams into one registered val/rdy output
//   clk       : clock, all state updates on posedge
//   reset     : asynchronous active-high reset
//   in_val    : per-requester valid (bit i = requester i)
//   in_rdy    : per-requester ready, one-hot or zero
//   in_msg    : packed messages, requester i at [i*p_width +: p_width]
//   in_done   : per-requester done flags
//   out_val   : output register holds a message
//   out_rdy   : consumer ready
//   out_msg   : registered message
//   out_src   : requester index that produced out_msg
//   all_done  : every requester done and output register empty
// Build option: define SOURCE_RR_ARBITER_FIXED_PRIO_EN for fixed priority (lowest valid index wins, no ptr).
module source_rr_arbiter #(
    parameter int p_width    = 32,
    parameter int p_nreqs    = 4,
    parameter int p_id_width = $clog2(p_nreqs)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [p_nreqs-1:0]         in_val,
    output logic [p_nreqs-1:0]         in_rdy,
    input  logic [p_nreqs*p_width-1:0] in_msg,
    input  logic [p_nreqs-1:0]         in_done,
    output logic                       out_val,
    input  logic                       out_rdy,
    output logic [p_width-1:0]         out_msg,
    output logic [p_id_width-1:0]      out_src,
    output logic                       all_done
);
    localparam logic [p_id_width-1:0] last_idx = p_id_width'(p_nreqs - 1);

    logic                  out_val_q, out_val_d;
    logic [p_width-1:0]    out_msg_q, out_msg_d;
    logic [p_id_width-1:0] out_src_q, out_src_d;
    logic                  load, any_val, hs;
    logic [p_id_width-1:0] gnt_idx, idx;
    logic [p_width-1:0]    gnt_msg;
    logic [p_width-1:0]    msgs [p_nreqs];
    int                    base;

    for (genvar g = 0; g < p_nreqs; g++) begin : g_unpack
        assign msgs[g] = in_msg[g*p_width +: p_width];
    end

`ifdef SOURCE_RR_ARBITER_FIXED_PRIO_EN
    assign base = 0;
`else
    logic [p_id_width-1:0] ptr_q, ptr_d;
    assign base = int'(ptr_q);
    assign ptr_d = hs ? (gnt_idx == last_idx ? '0 : gnt_idx + p_id_width'(1)) : ptr_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`endif

    // Scan from the farthest offset down so the nearest valid index (from base) wins last.
    always_comb begin
        any_val = 1'b0;
        gnt_idx = '0;
        gnt_msg = '0;
        idx     = '0;
        for (int k = p_nreqs - 1; k >= 0; k--) begin
            idx = p_id_width'((base + k) % p_nreqs);
            if (in_val[idx]) begin
                any_val = 1'b1;
                gnt_idx = idx;
                gnt_msg = msgs[idx];
            end
        end
    end

    assign load = !out_val_q | out_rdy;
    assign hs   = load & any_val;

    always_comb begin
        out_val_d = hs | (out_val_q & !out_rdy);
        out_msg_d = hs ? gnt_msg : out_msg_q;
        out_src_d = hs ? gnt_idx : out_src_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_val_q <= 1'b0;
            out_msg_q <= '0;
            out_src_q <= '0;
        end else begin
            out_val_q <= out_val_d;
            out_msg_q <= out_msg_d;
            out_src_q <= out_src_d;
        end
    end

    // Gated by reset so no requester sees an acknowledge in a reset cycle.
    assign in_rdy   = (hs & !reset) ? (p_nreqs'(1) << gnt_idx) : '0;
    assign out_val  = out_val_q;
    assign out_msg  = out_msg_q;
    assign out_src  = out_src_q;
    assign all_done = (&in_done) & !out_val_q;
endmodule

// File: tb/tb_source_rr_arbiter.sv
// tb_source_rr_arbiter: directed and random checks of source_rr_arbiter against a cycle-level reference model
module tb_source_rr_arbiter;
    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   in_val;
    logic [3:0]   in_rdy;
    logic [127:0] in_msg;
    logic [3:0]   in_done;
    logic         out_val;
    logic         out_rdy;
    logic [31:0]  out_msg;
    logic [1:0]   out_src;
    logic         all_done;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] msg [4];
    logic [31:0] delivered [$];

    logic        m_val;
    logic [31:0] m_msg;
    int          m_src;
    int          m_ptr;
    logic        m_hs;

    source_rr_arbiter dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .in_done(in_done), .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
        .out_src(out_src), .all_done(all_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_val = 1'b0;
        m_msg = '0;
        m_src = 0;
        m_ptr = 0;
        m_hs  = 1'b0;
    endtask

    // One cycle: drive inputs, check combinational outputs, clock, check registered outputs.
    task automatic step(input logic [3:0] v, input logic r, input logic [3:0] d);
        int g;
        int i;
        logic ld;
        logic [3:0] exp_rdy;
        in_val  = v;
        out_rdy = r;
        in_msg  = {msg[3], msg[2], msg[1], msg[0]};
        in_done = d;
        #1;
        g = -1;
        for (int k = 0; k < 4; k++) begin
`ifdef SOURCE_RR_ARBITER_FIXED_PRIO_EN
            i = k;
`else
            i = (m_ptr + k) % 4;
`endif
            if (g < 0 && v[i]) g = i;
        end
        ld      = !m_val || r;
        m_hs    = ld && g >= 0;
        exp_rdy = m_hs ? 4'(1 << g) : 4'b0;
        check("in_rdy", 64'(in_rdy), 64'(exp_rdy));
        check("all_done", 64'(all_done), 64'((&d) && !m_val));
        if (out_val && out_rdy) delivered.push_back(out_msg);
        @(posedge clk);
        #1;
        if (m_hs) begin
            m_val = 1'b1;
            m_msg = msg[g];
            m_src = g;
            m_ptr = (g + 1) % 4;
        end else if (ld) begin
            m_val = 1'b0;
        end
        check("out_val", 64'(out_val), 64'(m_val));
        check("out_msg", 64'(out_msg), 64'(m_msg));
        check("out_src", 64'(out_src), 64'(m_src));
    endtask

    initial begin
        int k;
        int cyc;
        reset   = 1'b1;
        in_val  = 4'b1111;
        out_rdy = 1'b1;
        in_msg  = '0;
        in_done = 4'b0;
        for (int j = 0; j < 4; j++) msg[j] = 32'hA0 + 32'(j);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_in_rdy", 64'(in_rdy), 64'(0));
        check("rst_out_val", 64'(out_val), 64'(0));
        check("rst_out_msg", 64'(out_msg), 64'(0));
        check("rst_out_src", 64'(out_src), 64'(0));
        reset = 1'b0;
        for (int j = 0; j < 5; j++) step(4'b0000, 1'b1, 4'b0000);

        for (int j = 0; j < 8; j++) step(4'b1111, 1'b1, 4'b0000);
        step(4'b0000, 1'b1, 4'b0000);

        msg[2] = 32'hDEADBEEF;
        step(4'b0100, 1'b1, 4'b0000);
        msg[1] = 32'h11111111;
        msg[3] = 32'h33333333;
        step(4'b1010, 1'b1, 4'b0000);
        step(4'b1010, 1'b1, 4'b0000);

        step(4'b0010, 1'b1, 4'b0000);
        for (int j = 0; j < 3; j++) step(4'b0101, 1'b0, 4'b0000);
        step(4'b0101, 1'b1, 4'b0000);
        step(4'b0000, 1'b1, 4'b0000);

        step(4'b0001, 1'b1, 4'b1111);
        step(4'b0000, 1'b0, 4'b1111);
        step(4'b0000, 1'b1, 4'b1111);
        step(4'b0000, 1'b1, 4'b1111);
        step(4'b0000, 1'b1, 4'b1011);

        step(4'b0000, 1'b1, 4'b0000);
        delivered.delete();
        k = 0;
        cyc = 0;
        while (k < 16 && cyc < 100) begin
            msg[0] = 32'(k);
            step(4'b0001, (cyc % 2) == 0, 4'b0000);
            if (m_hs) k++;
            cyc++;
        end
        check("stream_sent", 64'(k), 64'(16));
        for (int j = 0; j < 3; j++) step(4'b0000, 1'b1, 4'b0000);
        check("stream_count", 64'(delivered.size()), 64'(16));
        for (int j = 0; j < delivered.size() && j < 16; j++) check("stream_order", 64'(delivered[j]), 64'(j));

        for (int j = 0; j < 200; j++) begin
            for (int q = 0; q < 4; q++) msg[q] = $urandom;
            step(4'($urandom), 1'($urandom), 4'($urandom));
        end

        step(4'b0010, 1'b1, 4'b0000);
        step(4'b1111, 1'b0, 4'b0000);
        in_val  = 4'b1111;
        out_rdy = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out_val", 64'(out_val), 64'(0));
        check("mid_rst_in_rdy", 64'(in_rdy), 64'(0));
        check("mid_rst_out_msg", 64'(out_msg), 64'(0));
        @(posedge clk);
        #1;
        check("mid_rst_hold", 64'(out_val), 64'(0));
        reset = 1'b0;
        model_reset();
        step(4'b0000, 1'b1, 4'b0000);
        step(4'b0000, 1'b1, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
